debug_responder: RTL and testbench

DEBUG_RESPONDER -- requirements
Module: debug_responder

---
 rtl/debug_responder_pkg.sv | 22 ++
 rtl/debug_regfile.sv | 45 ++++
 rtl/debug_responder.sv | 108 ++++++++++
 tb/tb_debug_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_responder_pkg.sv
// Shared definitions for the debug run-control path.
// Holds the cpu_mode command encodings used by both the debug mux and
// debug_responder, the default data width, and the run-control state type.
package debug_responder_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    CM_NONE = 2'b00,
    CM_STOP = 2'b01,
    CM_RUN  = 2'b10,
    CM_STEP = 2'b11
  } cpu_mode_e;

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'b00,
    ST_RUN      = 2'b01,
    ST_STOPPING = 2'b10,
    ST_STEP     = 2'b11
  } run_state_e;

endpackage

// File: rtl/debug_regfile.sv
// debug_regfile: NREGS x DATA_WIDTH register file, cleared by reset.
// Ports:
//   clk, rst_n        clock, async active-low reset (clears every entry)
//   we, wsel, wdata   single write port; gating is done by the caller
//   ra_sel/ra_data    core read port A (combinational, no write-through)
//   rb_sel/rb_data    core read port B (combinational, no write-through)
//   rd_sel/rd_data    debug read port  (combinational, no write-through)
module debug_regfile
  import debug_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = debug_responder_pkg::DATA_WIDTH,
  parameter int unsigned NREGS      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [3:0]            wsel,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            ra_sel,
  output logic [DATA_WIDTH-1:0] ra_data,
  input  logic [3:0]            rb_sel,
  output logic [DATA_WIDTH-1:0] rb_data,
  input  logic [3:0]            rd_sel,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wsel] <= wdata;
    end
  end

  always_comb begin
    ra_data = regs[ra_sel];
    rb_data = regs[rb_sel];
    rd_data = regs[rd_sel];
  end

endmodule

// File: rtl/debug_responder.sv
// debug_responder: run-control FSM and debug-accessible register file.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   cpu_mode                    run-control command (none/stop/run/step)
//   reg_sel, reg_we, reg_wdata  debug register access (writes only in STOPPED)
//   reg_rdata                   debug read data, valid in every state
//   reg_stopped                 high while the core is STOPPED
//   exec_en                     core may issue/execute this cycle
//   instr_done                  core retire pulse
//   cw_en, cw_sel, cw_data      core register write (commits only with exec_en)
//   cra_sel/cra_data, crb_sel/crb_data  core read ports
module debug_responder
  import debug_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = debug_responder_pkg::DATA_WIDTH,
  parameter int unsigned NREGS      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cpu_mode,
  input  logic [3:0]            reg_sel,
  input  logic                  reg_we,
  input  logic [DATA_WIDTH-1:0] reg_wdata,
  output logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  reg_stopped,
  output logic                  exec_en,
  input  logic                  instr_done,
  input  logic                  cw_en,
  input  logic [3:0]            cw_sel,
  input  logic [DATA_WIDTH-1:0] cw_data,
  input  logic [3:0]            cra_sel,
  input  logic [3:0]            crb_sel,
  output logic [DATA_WIDTH-1:0] cra_data,
  output logic [DATA_WIDTH-1:0] crb_data
);

  run_state_e state_q, state_d;
  cpu_mode_e  cmd;

  logic                  core_we;
  logic                  dbg_we;
  logic                  rf_we;
  logic [3:0]            rf_wsel;
  logic [DATA_WIDTH-1:0] rf_wdata;

  assign cmd = cpu_mode_e'(cpu_mode);

  // Commands outrank instr_done when both arrive together.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOPPED: begin
        if (cmd == CM_RUN)       state_d = ST_RUN;
        else if (cmd == CM_STEP) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (cmd == CM_STOP || cmd == CM_STEP) state_d = ST_STOPPING;
      end
      ST_STOPPING, ST_STEP: begin
        if (cmd == CM_RUN)   state_d = ST_RUN;
        else if (instr_done) state_d = ST_STOPPED;
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // exec_en and reg_stopped are flopped from the next state so they change
  // on the same edge as the state register without any decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_STOPPED;
      exec_en     <= 1'b0;
      reg_stopped <= 1'b1;
    end else begin
      state_q     <= state_d;
      exec_en     <= (state_d != ST_STOPPED);
      reg_stopped <= (state_d == ST_STOPPED);
    end
  end

  // exec_en and reg_stopped are mutually exclusive, so the two writers never
  // collide and a simple select suffices.
  always_comb begin
    core_we  = cw_en && exec_en;
    dbg_we   = reg_we && reg_stopped;
    rf_we    = core_we || dbg_we;
    rf_wsel  = core_we ? cw_sel  : reg_sel;
    rf_wdata = core_we ? cw_data : reg_wdata;
  end

  debug_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NREGS      (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .wsel    (rf_wsel),
    .wdata   (rf_wdata),
    .ra_sel  (cra_sel),
    .ra_data (cra_data),
    .rb_sel  (crb_sel),
    .rb_data (crb_data),
    .rd_sel  (reg_sel),
    .rd_data (reg_rdata)
  );

endmodule

// File: tb/tb_debug_responder.sv
// Directed self-checking bench for debug_responder.
module tb_debug_responder;
  import debug_responder_pkg::*;

  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst_n;
  logic [1:0]    cpu_mode;
  logic [3:0]    reg_sel;
  logic          reg_we;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] reg_rdata;
  logic          reg_stopped;
  logic          exec_en;
  logic          instr_done;
  logic          cw_en;
  logic [3:0]    cw_sel;
  logic [DW-1:0] cw_data;
  logic [3:0]    cra_sel;
  logic [3:0]    crb_sel;
  logic [DW-1:0] cra_data;
  logic [DW-1:0] crb_data;

  int unsigned total = 0;
  int unsigned bad   = 0;

  debug_responder #(
    .DATA_WIDTH (DW),
    .NREGS      (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_mode    (cpu_mode),
    .reg_sel     (reg_sel),
    .reg_we      (reg_we),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .reg_stopped (reg_stopped),
    .exec_en     (exec_en),
    .instr_done  (instr_done),
    .cw_en       (cw_en),
    .cw_sel      (cw_sel),
    .cw_data     (cw_data),
    .cra_sel     (cra_sel),
    .crb_sel     (crb_sel),
    .cra_data    (cra_data),
    .crb_data    (crb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_run(input string tag, input logic exp_exec, input logic exp_stopped);
    check_eq({tag, "_exec"}, {31'd0, exec_en}, {31'd0, exp_exec});
    check_eq({tag, "_stopped"}, {31'd0, reg_stopped}, {31'd0, exp_stopped});
  endtask

  initial begin
    rst_n = 1'b0; cpu_mode = CM_NONE; reg_sel = '0; reg_we = 1'b0; reg_wdata = '0;
    instr_done = 1'b0; cw_en = 1'b0; cw_sel = '0; cw_data = '0; cra_sel = '0; crb_sel = '0;
    #12 rst_n = 1'b1;
    tick();

    // Reset then idle five cycles.
    repeat (5) tick();
    check_run("reset", 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      reg_sel = 4'(i); cra_sel = 4'(i); crb_sel = 4'(15 - i);
      #1;
      check_eq($sformatf("reset_rd%0d", i), {16'd0, reg_rdata}, 32'h0);
      check_eq($sformatf("reset_ra%0d", i), {16'd0, cra_data}, 32'h0);
      check_eq($sformatf("reset_rb%0d", i), {16'd0, crb_data}, 32'h0);
    end

    // Debug write while STOPPED; not visible until after the edge.
    reg_sel = 4'd3; reg_we = 1'b1; reg_wdata = 16'h00A5;
    #1;
    check_eq("dbg_no_wt", {16'd0, reg_rdata}, 32'h0);
    tick();
    reg_we = 1'b0;
    #1;
    check_eq("dbg_wr3", {16'd0, reg_rdata}, 32'h00A5);

    // Run, then a debug write must be dropped.
    cpu_mode = CM_RUN;
    tick();
    cpu_mode = CM_NONE;
    check_run("run", 1'b1, 1'b0);
    reg_we = 1'b1; reg_wdata = 16'h1234;
    tick();
    reg_we = 1'b0;
    #1;
    check_eq("dbg_drop_run", {16'd0, reg_rdata}, 32'h00A5);
    tick();
    check_run("run_idle", 1'b1, 1'b0);

    // Step from RUN goes to STOPPING; instr_done ends it.
    cpu_mode = CM_STEP;
    tick();
    cpu_mode = CM_NONE;
    check_run("run_step_stopping", 1'b1, 1'b0);
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    check_run("stopping_done", 1'b0, 1'b1);

    // Single step with core write on the retiring cycle; stop is ignored in STEP.
    cra_sel = 4'd5;
    cpu_mode = CM_STEP;
    tick();
    cpu_mode = CM_NONE;
    check_run("step_c1", 1'b1, 1'b0);
    cpu_mode = CM_STOP;
    tick();
    cpu_mode = CM_NONE;
    check_run("step_c2", 1'b1, 1'b0);
    tick();
    check_run("step_c3", 1'b1, 1'b0);
    instr_done = 1'b1; cw_en = 1'b1; cw_sel = 4'd5; cw_data = 16'h0007;
    #1;
    check_eq("cw_no_wt", {16'd0, cra_data}, 32'h0);
    tick();
    instr_done = 1'b0; cw_en = 1'b0;
    check_run("step_end", 1'b0, 1'b1);
    check_eq("step_reg5", {16'd0, cra_data}, 32'h0007);

    // Stay stopped on stop/none.
    cpu_mode = CM_STOP;
    tick();
    cpu_mode = CM_NONE;
    tick();
    check_run("stopped_hold", 1'b0, 1'b1);

    // RUN, stop, four cycles without retire.
    cpu_mode = CM_RUN;
    tick();
    cpu_mode = CM_STOP;
    tick();
    cpu_mode = CM_NONE;
    for (int i = 0; i < 4; i++) begin
      check_run($sformatf("stopping_w%0d", i), 1'b1, 1'b0);
      tick();
    end
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    check_run("stopping_end", 1'b0, 1'b1);

    // STOPPING with run and instr_done together -> RUN; retire still writes.
    cpu_mode = CM_RUN;
    tick();
    cpu_mode = CM_STOP;
    tick();
    check_run("pre_race", 1'b1, 1'b0);
    crb_sel = 4'd9;
    cpu_mode = CM_RUN; instr_done = 1'b1; cw_en = 1'b1; cw_sel = 4'd9; cw_data = 16'h0055;
    tick();
    cpu_mode = CM_NONE; instr_done = 1'b0; cw_en = 1'b0;
    check_run("race_run", 1'b1, 1'b0);
    check_eq("race_reg9", {16'd0, crb_data}, 32'h0055);
    // A lone instr_done in RUN must not stop the core.
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    check_run("run_done_stays", 1'b1, 1'b0);

    // Back to STOPPED, then step and reset mid-cycle.
    cpu_mode = CM_STOP;
    tick();
    cpu_mode = CM_NONE;
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    check_run("pre_step", 1'b0, 1'b1);
    cpu_mode = CM_STEP;
    tick();
    cpu_mode = CM_NONE;
    check_run("step_before_rst", 1'b1, 1'b0);
    reg_sel = 4'd3; cra_sel = 4'd5; crb_sel = 4'd9;
    #3 rst_n = 1'b0;
    #1;
    check_run("async_rst", 1'b0, 1'b1);
    check_eq("rst_reg3", {16'd0, reg_rdata}, 32'h0);
    check_eq("rst_reg5", {16'd0, cra_data}, 32'h0);
    check_eq("rst_reg9", {16'd0, crb_data}, 32'h0);
    tick();
    rst_n = 1'b1;

    // Core write while exec_en is low is ignored; stays STOPPED.
    cra_sel = 4'd2;
    cw_en = 1'b1; cw_sel = 4'd2; cw_data = 16'hBEEF;
    tick();
    cw_en = 1'b0;
    tick();
    check_eq("cw_ignored", {16'd0, cra_data}, 32'h0);
    check_run("post_rst_hold", 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
